// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the MEM-stage load/store unit.
// Optional build macro: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_W = 16;

    // Reserved funct3 encodings fall back to a word access.
    function automatic lsu_size_e size_of(
        input logic [2:0] f3
    );
        lsu_size_e sz;
        unique case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic [1:0] eff_off(
        input lsu_size_e  sz,
        input logic [1:0] off
    );
        logic [1:0] o;
        unique case (sz)
            SZ_B:    o = off;
            SZ_H:    o = {off[1], 1'b0};
            default: o = 2'b00;
        endcase
        return o;
    endfunction

    function automatic logic is_misal(
        input lsu_size_e  sz,
        input logic [1:0] off
    );
        logic m;
        unique case (sz)
            SZ_H:    m = off[0];
            SZ_W:    m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus valid/ack interface between the LSU and data memory.
interface lsu_if;

    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        dbus_err;

    modport master (
        output dbus_req,
        output dbus_we,
        output dbus_addr,
        output dbus_wdata,
        output dbus_be,
        input  dbus_ack,
        input  dbus_rdata,
        input  dbus_err
    );

    modport slave (
        input  dbus_req,
        input  dbus_we,
        input  dbus_addr,
        input  dbus_wdata,
        input  dbus_be,
        output dbus_ack,
        output dbus_rdata,
        output dbus_err
    );

endinterface

// File: rtl/lsu_align.sv
// Store lane/byte-enable generation and load extract/extend.
// Purely combinational; the offset is masked to the access size.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        st_write,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    lsu_size_e  st_sz;
    lsu_size_e  ld_sz;
    logic [1:0] so;
    logic [1:0] lo;
    logic [7:0] ld_b;
    logic [15:0] ld_h;
    logic       sx;

    always_comb begin
        st_sz   = size_of(st_funct3);
        so      = eff_off(st_sz, st_off);
        st_be   = 4'b1111;
        st_lane = st_data;
        if (st_write) begin
            unique case (1'b1)
                st_sz == SZ_B: begin
                    st_be   = 4'b0001 << so;
                    st_lane = {4{st_data[7:0]}};
                end
                st_sz == SZ_H: begin
                    st_be   = so[1] ? 4'b1100 : 4'b0011;
                    st_lane = {2{st_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_sz = size_of(ld_funct3);
        lo    = eff_off(ld_sz, ld_off);
        sx    = ~ld_funct3[2];
        unique case (lo)
            2'd0:    ld_b = ld_word[7:0];
            2'd1:    ld_b = ld_word[15:8];
            2'd2:    ld_b = ld_word[23:16];
            default: ld_b = ld_word[31:24];
        endcase
        ld_h = lo[1] ? ld_word[31:16] : ld_word[15:0];
        unique case (1'b1)
            ld_sz == SZ_B:
                ld_data = {{24{sx & ld_b[7]}}, ld_b};
            ld_sz == SZ_H:
                ld_data = {{16{sx & ld_h[15]}}, ld_h};
            default:
                ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: IDLE/BUSY/DONE bus sequencer with timeout.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned accesses trap).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
    output logic        misalign,
    lsu_if.master       dbus
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST =
        TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e state_q;
    lsu_state_e state_d;

    logic [29:0]          addr_q;
    logic [1:0]           off_q;
    logic [2:0]           f3_q;
    logic                 we_q;
    logic [3:0]           be_q;
    logic [31:0]          wdata_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 err_q;
    logic [31:0]          ldata_q;

    logic        take;
    logic        trap_req;
    logic        fin_ok;
    logic        fin_err;
    logic [3:0]  st_be;
    logic [31:0] st_lane;
    logic [31:0] ld_fmt;

    lsu_align u_align (
        .st_write  (req_write),
        .st_funct3 (req_funct3),
        .st_off    (req_addr[1:0]),
        .st_data   (req_wdata),
        .st_be     (st_be),
        .st_lane   (st_lane),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_word   (dbus.dbus_rdata),
        .ld_data   (ld_fmt)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign trap_req = is_misal(size_of(req_funct3), req_addr[1:0]);
    assign misalign = (state_q == DONE) & mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (take) begin
            mis_q <= trap_req;
        end
    end
`else
    assign trap_req = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        fin_ok  = 1'b0;
        fin_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    take    = 1'b1;
                    state_d = trap_req ? DONE : BUSY;
                end
            end
            BUSY: begin
                // error beats a simultaneous ack; ack beats the timeout
                if (dbus.dbus_err) begin
                    fin_err = 1'b1;
                    state_d = DONE;
                end else if (dbus.dbus_ack) begin
                    fin_ok  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    fin_err = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                addr_q  <= req_addr[31:2];
                off_q   <= req_addr[1:0];
                f3_q    <= req_funct3;
                we_q    <= req_write;
                be_q    <= st_be;
                wdata_q <= st_lane;
                cnt_q   <= '0;
                err_q   <= 1'b0;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fin_err) begin
                err_q   <= 1'b1;
                ldata_q <= '0;
            end else if (fin_ok && !we_q) begin
                ldata_q <= ld_fmt;
            end else if (take && trap_req) begin
                ldata_q <= '0;
            end
        end
    end

    assign lsu_stall = ((state_q == IDLE) & req_valid)
                     | (state_q == BUSY);
    assign load_data  = ldata_q;
    assign load_valid = (state_q == DONE) & ~we_q;
    assign bus_err    = (state_q == DONE) & err_q;

    assign dbus.dbus_req   = (state_q == BUSY);
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = {addr_q, 2'b00};
    assign dbus.dbus_wdata = wdata_q;
    assign dbus.dbus_be    = be_q;

endmodule
